// File: rtl/vpm_pipe_sink.sv
// rtl/vpm_pipe_sink.sv - credit-controlled receive FIFO at the tail of a fixed-latency VPM pipeline
// Optional synchronous flush port enabled by defining VPM_PIPE_SINK_FLUSH_EN.
module vpm_pipe_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_issue,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef VPM_PIPE_SINK_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH:0]   SUM_LIMIT = (CNT_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d, infl_q, infl_d;
  logic                  ovf_err_q, ovf_err_d;
  logic [CNT_WIDTH:0]    credit_sum;
  logic                  full, push, pop;

  assign full       = (occ_q == CNT_FULL);
  assign pop        = (occ_q != '0) && out_ready;
  // Popping frees the slot in the same cycle, so a full buffer still accepts a word alongside a pop.
  assign push       = in_valid && (!full || pop);
  assign credit_sum = {1'b0, occ_q} + {1'b0, infl_q};

  assign stall     = (credit_sum >= SUM_LIMIT);
  assign out_valid = (occ_q != '0);
  assign out_data  = mem[rptr_q];
  assign ovf_err   = ovf_err_q;

  always_comb begin
    wptr_d    = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d    = pop ? rptr_q + PTR_ONE : rptr_q;
    occ_d     = occ_q;
    infl_d    = infl_q;
    ovf_err_d = ovf_err_q;

    if (push && !pop) begin
      occ_d = occ_q + CNT_ONE;
    end else if (!push && pop) begin
      occ_d = occ_q - CNT_ONE;
    end

    if (in_issue && !in_valid) begin
      infl_d = infl_q + CNT_ONE;
    end else if (!in_issue && in_valid && (infl_q != '0)) begin
      infl_d = infl_q - CNT_ONE;
    end

    // Issue past the credit limit, a word landing on a full buffer, or a word nobody issued.
    if ((in_issue && stall) ||
        (in_valid && full && !pop) ||
        (in_valid && !in_issue && (infl_q == '0))) begin
      ovf_err_d = 1'b1;
    end

`ifdef VPM_PIPE_SINK_FLUSH_EN
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      infl_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      infl_q    <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= in_data;
    end
  end

endmodule
